// File: rtl/mult_acc_seq.sv
// mult_acc_seq: sequential multiply-accumulate controller wrapped around an
// external 8x8 signed combinational multiplier. Operand pairs arrive over a
// valid/ready handshake, are registered onto the multiplier inputs, and the
// returned product is summed into a saturating signed accumulator.
module mult_acc_seq #(
   parameter int ACC_WIDTH   = 24,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Start,
   input  logic [COUNT_WIDTH-1:0] Length,
   input  logic                   In_Valid,
   output logic                   In_Ready,
   input  logic [7:0]             In_A,
   input  logic [7:0]             In_B,
   output logic [7:0]             Mult_A,
   output logic [7:0]             Mult_B,
   input  logic [15:0]            Product,
   output logic [ACC_WIDTH-1:0]   Acc_Out,
   output logic                   Acc_Valid,
   output logic                   Overflow,
   output logic                   Busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_OP = 2'd1,
      S_MUL     = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t                  r_state;
   logic [COUNT_WIDTH-1:0]  r_cnt;
   logic [7:0]              r_mult_a;
   logic [7:0]              r_mult_b;
   logic [ACC_WIDTH-1:0]    r_acc;
   logic                    r_ovf;

   // One guard bit above the accumulator exposes signed overflow of the add.
   logic signed [ACC_WIDTH:0] w_acc_ext;
   logic signed [ACC_WIDTH:0] w_prod_ext;
   logic signed [ACC_WIDTH:0] w_sum;
   logic                      w_sat_hi;
   logic                      w_sat_lo;

   assign w_acc_ext  = (ACC_WIDTH+1)'($signed(r_acc));
   assign w_prod_ext = (ACC_WIDTH+1)'($signed(Product));
   assign w_sum      = w_acc_ext + w_prod_ext;
   // Guard bit and MSB disagree only when the true sum left the signed range.
   assign w_sat_hi   = (w_sum[ACC_WIDTH] == 1'b0) && (w_sum[ACC_WIDTH-1] == 1'b1);
   assign w_sat_lo   = (w_sum[ACC_WIDTH] == 1'b1) && (w_sum[ACC_WIDTH-1] == 1'b0);

   assign In_Ready  = (r_state == S_WAIT_OP);
   assign Busy      = (r_state != S_IDLE);
   assign Acc_Valid = (r_state == S_DONE);
   assign Mult_A    = r_mult_a;
   assign Mult_B    = r_mult_b;
   assign Acc_Out   = r_acc;
   assign Overflow  = r_ovf;

   // Run sequencing: accept Start, collect pairs, saturating accumulate, report.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mult_a <= '0;
         r_mult_b <= '0;
         r_acc    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_acc <= '0;
                  r_ovf <= 1'b0;
                  if (Length != '0) begin
                     r_cnt   <= Length;
                     r_state <= S_WAIT_OP;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_WAIT_OP: begin
               if (In_Valid) begin
                  r_mult_a <= In_A;
                  r_mult_b <= In_B;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               // Clamp per add; Overflow stays set until the next Start.
               if (w_sat_hi) begin
                  r_acc <= ACC_MAX;
                  r_ovf <= 1'b1;
               end else if (w_sat_lo) begin
                  r_acc <= ACC_MIN;
                  r_ovf <= 1'b1;
               end else begin
                  r_acc <= w_sum[ACC_WIDTH-1:0];
               end
               r_cnt   <= r_cnt - 1'b1;
               r_state <= (r_cnt == COUNT_WIDTH'(1)) ? S_DONE : S_WAIT_OP;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_acc_seq.sv
// Bench for mult_acc_seq with a 16-bit accumulator so saturation is easy to
// reach. The multiplier is modelled as plain signed arithmetic on Mult_A/B.
module tb_mult_acc_seq;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic [7:0]  Length;
   logic        In_Valid;
   logic        In_Ready;
   logic [7:0]  In_A, In_B;
   logic [7:0]  Mult_A, Mult_B;
   logic [15:0] Product;
   logic [15:0] Acc_Out;
   logic        Acc_Valid;
   logic        Overflow;
   logic        Busy;

   int total = 0;
   int bad   = 0;
   int vcnt  = 0;
   int rcnt  = 0;

   logic [7:0] pa [16];
   logic [7:0] pb [16];

   always #5 Clk = ~Clk;

   assign Product = 16'($signed(Mult_A)) * 16'($signed(Mult_B));

   mult_acc_seq #(.ACC_WIDTH(16), .COUNT_WIDTH(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Length(Length),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_A(In_A), .In_B(In_B),
      .Mult_A(Mult_A), .Mult_B(Mult_B), .Product(Product),
      .Acc_Out(Acc_Out), .Acc_Valid(Acc_Valid), .Overflow(Overflow), .Busy(Busy)
   );

   always @(posedge Clk) begin
      if (Acc_Valid === 1'b1) vcnt++;
      if (In_Ready === 1'b1) rcnt++;
   end

   // Reference: plain integer sum, clamped into 16-bit signed after every add.
   function automatic void model(input int len, output logic [15:0] acc, output logic ovf);
      int s;
      s = 0; ovf = 1'b0;
      for (int i = 0; i < len; i++) begin
         s = s + int'($signed(pa[i])) * int'($signed(pb[i]));
         if (s > 32767) begin s = 32767; ovf = 1'b1; end
         else if (s < -32768) begin s = -32768; ovf = 1'b1; end
      end
      acc = s[15:0];
   endfunction

   function automatic int exp_lat(input int len, input int gap);
      return 2*len + 1 + ((len > 0) ? gap*(len-1) : 0);
   endfunction

   // Drives one full run and reports what was observed.
   task automatic drive_run(input int len, input int gap, input bit noise,
                            output int lat, output logic [15:0] acc, output logic ovf,
                            output int merr, output int tmo, output int pulses,
                            output logic [15:0] acc_hold, output logic vld_after);
      int cyc, v0, k;
      merr = 0; tmo = 0; v0 = vcnt;
      @(posedge Clk); #1; Start = 1'b1; Length = len[7:0];
      @(posedge Clk); #1; Start = 1'b0; cyc = 1;
      for (int i = 0; i < len; i++) begin
         In_A = pa[i]; In_B = pb[i];
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               In_Valid = 1'b0;
               if (noise) begin Start = 1'b1; Length = 8'd1; end
               @(negedge Clk);
               if (In_Ready !== 1'b1 || Busy !== 1'b1) merr++;
               @(posedge Clk); #1; Start = 1'b0; cyc++;
            end
         end
         In_Valid = 1'b1;
         for (k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (In_Ready === 1'b1) break;
            @(posedge Clk); #1; cyc++;
         end
         if (k == 10) tmo++;
         @(posedge Clk); #1; In_Valid = 1'b0; cyc++;
         @(negedge Clk);
         if (Mult_A !== pa[i] || Mult_B !== pb[i] || In_Ready !== 1'b0) merr++;
         @(posedge Clk); #1; cyc++;
      end
      for (k = 0; k < 10; k++) begin
         @(negedge Clk);
         if (Acc_Valid === 1'b1) break;
         @(posedge Clk); #1; cyc++;
      end
      if (k == 10) tmo++;
      lat = cyc; acc = Acc_Out; ovf = Overflow;
      @(posedge Clk); #1;
      @(negedge Clk); vld_after = Acc_Valid; acc_hold = Acc_Out;
      @(posedge Clk); #1;
      pulses = vcnt - v0;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Start = 1'b0; Length = '0; In_Valid = 1'b0; In_A = '0; In_B = '0;
      #3;
      total++;
      if ({Mult_A, Mult_B, Acc_Out, Acc_Valid, Overflow, In_Ready, Busy} !== 36'd0) begin
         bad++; $display("FAIL reset_state: got %h expected 0",
                         {Mult_A, Mult_B, Acc_Out, Acc_Valid, Overflow, In_Ready, Busy});
      end
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      total++;
      if (Busy !== 1'b0 || In_Ready !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: busy=%b rdy=%b expected 0/0", Busy, In_Ready);
      end
   endtask

   // Fixed-vector scenario: checks latency, result, flag, one pulse, hold.
   task automatic test_vector(input string name, input int len, input int gap, input bit noise);
      int lat, merr, tmo, pulses;
      logic [15:0] acc, acc_hold, eacc;
      logic ovf, eovf, vld_after;
      model(len, eacc, eovf);
      drive_run(len, gap, noise, lat, acc, ovf, merr, tmo, pulses, acc_hold, vld_after);
      total++;
      if (acc !== eacc || ovf !== eovf) begin
         bad++; $display("FAIL %s_result: acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         name, $signed(acc), ovf, $signed(eacc), eovf);
      end
      total++;
      if (lat !== exp_lat(len, gap) || tmo !== 0) begin
         bad++; $display("FAIL %s_latency: got %0d (timeouts %0d) expected %0d",
                         name, lat, tmo, exp_lat(len, gap));
      end
      total++;
      if (merr !== 0) begin
         bad++; $display("FAIL %s_operands: %0d bad operand/ready samples expected 0", name, merr);
      end
      total++;
      if (pulses !== 1 || vld_after !== 1'b0 || acc_hold !== eacc) begin
         bad++; $display("FAIL %s_pulse_hold: pulses=%0d vld_after=%b hold=%0d expected 1/0/%0d",
                         name, pulses, vld_after, $signed(acc_hold), $signed(eacc));
      end
   endtask

   task automatic test_basic();
      pa[0] = 8'd11; pb[0] = 8'd3;
      test_vector("single", 1, 0, 1'b0);
      pa[1] = 8'd11; pb[1] = 8'hFD;
      test_vector("cancel", 2, 0, 1'b0);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin pa[i] = 8'd127; pb[i] = 8'd127; end
      test_vector("sat_pos", 3, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin pa[i] = 8'h80; pb[i] = 8'd127; end
      test_vector("sat_neg", 3, 0, 1'b0);
      // Clamp then come back in range: flag must stay set.
      pa[0] = 8'd127; pb[0] = 8'd127; pa[1] = 8'd127; pb[1] = 8'd127;
      pa[2] = 8'd127; pb[2] = 8'd127; pa[3] = 8'h80; pb[3] = 8'd127;
      test_vector("sat_sticky", 4, 0, 1'b0);
   endtask

   task automatic test_len_zero();
      int r0;
      r0 = rcnt;
      test_vector("len0", 0, 0, 1'b0);
      total++;
      if (rcnt - r0 !== 0) begin
         bad++; $display("FAIL len0_ready: ready cycles=%0d expected 0", rcnt - r0);
      end
   endtask

   task automatic test_stall();
      pa[0] = 8'h80; pb[0] = 8'h80; pa[1] = 8'd1; pb[1] = 8'hFF;
      test_vector("stall", 2, 5, 1'b1);
   endtask

   task automatic test_reset_midrun();
      int v0, tmo;
      v0 = vcnt; tmo = 0;
      @(posedge Clk); #1; Start = 1'b1; Length = 8'd3;
      @(posedge Clk); #1; Start = 1'b0; In_A = 8'd9; In_B = 8'd7; In_Valid = 1'b1;
      @(posedge Clk); #1; In_Valid = 1'b0;
      total++;
      if (Mult_A !== 8'd9 || Busy !== 1'b1) begin
         bad++; $display("FAIL midrun_accept: mult_a=%0d busy=%b expected 9/1", Mult_A, Busy);
      end
      #2; Rst_n = 1'b0; #1;
      total++;
      if ({Mult_A, Mult_B, Acc_Out, Acc_Valid, Overflow, In_Ready, Busy} !== 36'd0) begin
         bad++; $display("FAIL midrun_reset: got %h expected 0",
                         {Mult_A, Mult_B, Acc_Out, Acc_Valid, Overflow, In_Ready, Busy});
      end
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (6) @(negedge Clk);
      total++;
      if (vcnt - v0 !== 0 || Busy !== 1'b0) begin
         bad++; $display("FAIL midrun_abort: pulses=%0d busy=%b expected 0/0", vcnt - v0, Busy);
      end
      pa[0] = 8'd2; pb[0] = 8'd3;
      test_vector("after_reset", 1, 0, 1'b0);
   endtask

   // Back-to-back random runs; some biased to extreme operands to hit clamps.
   task automatic test_random();
      for (int r = 0; r < 12; r++) begin
         int len, gap;
         len = $urandom_range(1, 8);
         gap = $urandom_range(0, 2);
         for (int i = 0; i < len; i++) begin
            if (r % 3 == 0) begin
               pa[i] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'd127;
               pb[i] = ($urandom_range(0, 1) == 1) ? 8'h81 : 8'd127;
            end else begin
               pa[i] = 8'($urandom_range(0, 255));
               pb[i] = 8'($urandom_range(0, 255));
            end
         end
         test_vector("random", len, gap, r[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_len_zero();
      test_stall();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_acc_seq.md
Name: mult_acc_seq

Overview:
- Sequential multiply-accumulate controller that sits around the 8x8 signed combinational multiplier (mult_8bit).
- Upstream role: accepts operand pairs over a valid/ready handshake and drives registered operands onto the multiplier inputs.
- Downstream role: captures the multiplier's 16-bit signed Product and accumulates it into a saturating signed accumulator over a programmed number of pairs.
- Reports the final sum with a one-cycle valid pulse.

Parameters:
- ACC_WIDTH, 24: accumulator width in bits, signed. Legal range 16..32.
- COUNT_WIDTH, 8: width of Length and of the internal remaining-pairs counter.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  begin a new accumulation; honoured only in IDLE
- Length  input  COUNT_WIDTH  number of operand pairs, sampled when Start is accepted
- In_Valid  input  1  operand pair valid
- In_Ready  output  1  block can accept an operand pair
- In_A  input  8  signed multiplier operand
- In_B  input  8  signed multiplicand operand
- Mult_A  output  8  registered operand to mult_8bit Multiplier
- Mult_B  output  8  registered operand to mult_8bit Multiplicand
- Product  input  16  signed product from mult_8bit; combinational from Mult_A/Mult_B
- Acc_Out  output  ACC_WIDTH  signed accumulated result
- Acc_Valid  output  1  one-cycle pulse when Acc_Out is final
- Overflow  output  1  sticky saturation flag for the current run
- Busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low.
  - State becomes IDLE.
  - Mult_A, Mult_B, Acc_Out, remaining counter: 0.
  - Acc_Valid, Overflow, In_Ready, Busy: 0.
  - A reset mid-run aborts the run; there is no partial result and no Acc_Valid pulse.
- States: IDLE, WAIT_OP, MUL, DONE.
- IDLE:
  - Start=1 and Length!=0: load counter with Length, clear Acc_Out and Overflow, go to WAIT_OP.
  - Start=1 and Length==0: clear Acc_Out and Overflow, go to DONE.
  - Acc_Out and Overflow otherwise hold their last values.
- WAIT_OP:
  - In_Ready=1, combinationally derived from state.
  - On In_Valid&&In_Ready: register In_A to Mult_A and In_B to Mult_B, go to MUL.
  - In_Valid low: stay in WAIT_OP indefinitely.
- MUL:
  - In_Ready=0.
  - Sample Product and sign-extend it to ACC_WIDTH.
  - Compute the sum at ACC_WIDTH+1 bits.
  - Above max positive: Acc_Out is clamped to 2^(ACC_WIDTH-1)-1 and Overflow is set.
  - Below min negative: Acc_Out is clamped to -2^(ACC_WIDTH-1) and Overflow is set.
  - Decrement the counter. Go to DONE if the counter was 1, else to WAIT_OP.
- DONE:
  - Acc_Valid=1 for exactly this cycle, then go to IDLE.
  - Acc_Out is stable from DONE until the next accepted Start.
- Mult_A/Mult_B hold their values outside the WAIT_OP handshake.
- Start while Busy is ignored; it is neither queued nor restarted.
- Throughput: one pair per 2 cycles minimum.
- Latency, Start accepted to Acc_Valid: 2*Length+1 cycles with In_Valid held high. Length==0 gives Acc_Valid one cycle after Start.
- Overflow stays set for the rest of the run, even if later products move the sum back in range.
- Saturation is per-add; subsequent adds operate on the clamped value.

Test Plan:
- Length=1, pair (A=8'b00001011, B=8'b00000011) -> Mult_A/Mult_B=11/3 in MUL; Acc_Out=33, Acc_Valid pulse at cycle 3 after Start, Overflow=0.
- Length=2, pairs (11,3) then (11,-3 i.e. 8'b11111101) -> Acc_Out=0, Overflow=0, exactly one Acc_Valid pulse.
- ACC_WIDTH=16, Length=3, pairs (127,127) x3 -> Acc_Out=32767, Overflow=1. Repeat with (-128,127) x3 -> Acc_Out=-32768, Overflow=1.
- Length=0 with Start -> Acc_Valid the next cycle, Acc_Out=0; In_Ready never asserted.
- Length=2, In_Valid low for 5 cycles between pairs (-128,-128) and (1,-1) -> In_Ready held high while waiting, no progress. Result Acc_Out=16383; Start pulsed during the run is ignored.
- Reset asserted mid-run after the first pair is accepted -> all outputs immediately 0 and state IDLE; after release, a new Start with Length=1 and (2,3) -> Acc_Out=6.
